// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback select encoding, writeback FSM states,
// and register-file geometry.
package cpu_pkg;

    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_MEM = 2'b01,
        ST_WRITE    = 2'b10
    } wb_state_e;

    // True when a write to this register must be dropped (hard-wired zero register).
    function automatic logic is_ro_reg(input logic [REG_AW-1:0] addr, input int ro_en);
        return (ro_en != 0) && (addr == {REG_AW{1'b0}});
    endfunction

endpackage

// File: rtl/writeback_stage.sv
// Writeback stage: selects the retiring value, waits on load data, drives the
// register-file write port and publishes a pending-load scoreboard.
module writeback_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NREG        = cpu_pkg::NREG,
    parameter int MEM_TIMEOUT = 64,
    parameter int ZERO_REG_RO = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [REG_AW-1:0]       in_dest,
    input  logic                    in_write_reg,
    input  logic [1:0]              in_wb_sel,
    input  logic [DATA_W-1:0]       in_alu_result,
    input  logic [DATA_W-1:0]       in_imm,
    input  logic [DATA_W-1:0]       in_pc_plus4,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_rvalid,
    output logic [DATA_W-1:0]       write_reg_data,
    output logic                    write_reg,
    output logic [REG_AW-1:0]       write_reg_addr,
    output logic [NREG-1:0]         busy_mask,
    output logic                    wb_err
);

    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    wb_state_e          r_state;
    logic [DATA_W-1:0]  r_data;
    logic               r_we;
    logic [REG_AW-1:0]  r_addr;
    logic [NREG-1:0]    r_busy;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;

    wb_state_e          w_state_nxt;
    logic [DATA_W-1:0]  w_data_nxt;
    logic               w_we_nxt;
    logic [REG_AW-1:0]  w_addr_nxt;
    logic [NREG-1:0]    w_busy_nxt;
    logic               w_err_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_accept;
    logic [DATA_W-1:0]  w_sel_data;

    assign in_ready       = (r_state != ST_WAIT_MEM);
    assign w_accept       = in_valid && in_ready;
    assign write_reg_data = r_data;
    assign write_reg      = r_we;
    assign write_reg_addr = r_addr;
    assign busy_mask      = r_busy;
    assign wb_err         = r_err;

    // Non-load writeback value mux.
    always_comb begin
        w_sel_data = in_alu_result;
        case (in_wb_sel)
            WB_ALU:  w_sel_data = in_alu_result;
            WB_PC:   w_sel_data = in_pc_plus4;
            WB_IMM:  w_sel_data = in_imm;
            default: w_sel_data = in_alu_result;
        endcase
    end

    // Next-state, scoreboard and write-port computation.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_data_nxt  = r_data;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_busy_nxt  = r_busy;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE, ST_WRITE: begin
                // A completing load releases its scoreboard bit this cycle.
                if (r_state == ST_WRITE) begin
                    w_busy_nxt[r_addr] = 1'b0;
                end else begin
                    w_busy_nxt = r_busy;
                end
                if (w_accept && in_write_reg) begin
                    w_addr_nxt = in_dest;
                    if (in_wb_sel == WB_MEM) begin
                        w_state_nxt = ST_WAIT_MEM;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                        if (!is_ro_reg(in_dest, ZERO_REG_RO)) begin
                            w_busy_nxt[in_dest] = 1'b1;
                        end else begin
                            w_busy_nxt[in_dest] = 1'b0;
                        end
                    end else begin
                        w_state_nxt = ST_WRITE;
                        w_data_nxt  = w_sel_data;
                        w_we_nxt    = !is_ro_reg(in_dest, ZERO_REG_RO);
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                // Data arriving on the last allowed cycle still wins over the timeout.
                if (mem_rvalid) begin
                    w_state_nxt = ST_WRITE;
                    w_data_nxt  = mem_rdata;
                    w_we_nxt    = !is_ro_reg(r_addr, ZERO_REG_RO);
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt        = ST_IDLE;
                    w_err_nxt          = 1'b1;
                    w_busy_nxt[r_addr] = 1'b0;
                    w_cnt_nxt          = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_WAIT_MEM;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_data  <= {DATA_W{1'b0}};
            r_we    <= 1'b0;
            r_addr  <= {REG_AW{1'b0}};
            r_busy  <= {NREG{1'b0}};
            r_err   <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a transaction-level model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_writeback_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_dest = 5'd0;
    logic        in_write_reg = 1'b0;
    logic [1:0]  in_wb_sel = 2'b00;
    logic [31:0] in_alu_result = 32'd0;
    logic [31:0] in_imm = 32'd0;
    logic [31:0] in_pc_plus4 = 32'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] write_reg_data;
    logic        write_reg;
    logic [4:0]  write_reg_addr;
    logic [31:0] busy_mask;
    logic        wb_err;

    int n_vec = 0;
    int n_err = 0;

    writeback_stage #(
        .DATA_W(32), .NREG(32), .MEM_TIMEOUT(TO), .ZERO_REG_RO(1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_dest(in_dest), .in_write_reg(in_write_reg), .in_wb_sel(in_wb_sel),
        .in_alu_result(in_alu_result), .in_imm(in_imm), .in_pc_plus4(in_pc_plus4),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .write_reg_data(write_reg_data), .write_reg(write_reg),
        .write_reg_addr(write_reg_addr), .busy_mask(busy_mask), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          live = 1'b0;
    bit          m_pending, m_slot, m_we, m_err, nslot;
    int          m_waited;
    logic [4:0]  m_dest, m_slot_addr, m_addr, naddr;
    logic [31:0] m_data, ndata, m_busy;

    always @(posedge clk) begin
        if (rst) begin
            live = 1'b1; m_pending = 1'b0; m_slot = 1'b0; m_we = 1'b0; m_err = 1'b0;
            m_waited = 0; m_dest = 5'd0; m_slot_addr = 5'd0; m_addr = 5'd0;
            m_data = 32'd0; m_busy = 32'd0;
        end else begin
            if (m_slot) m_busy[m_slot_addr] = 1'b0;
            nslot = 1'b0; naddr = 5'd0; ndata = 32'd0;
            if (m_pending) begin
                if (mem_rvalid) begin
                    nslot = 1'b1; naddr = m_dest; ndata = mem_rdata; m_pending = 1'b0;
                end else begin
                    m_waited++;
                    if (m_waited == TO) begin
                        m_err = 1'b1; m_busy[m_dest] = 1'b0; m_pending = 1'b0;
                    end
                end
            end else if (in_valid && in_write_reg) begin
                if (in_wb_sel == 2'b01) begin
                    m_pending = 1'b1; m_dest = in_dest; m_waited = 0;
                    m_addr = in_dest;
                    if (in_dest != 5'd0) m_busy[in_dest] = 1'b1;
                end else begin
                    nslot = 1'b1; naddr = in_dest;
                    ndata = (in_wb_sel == 2'b00) ? in_alu_result :
                            (in_wb_sel == 2'b10) ? in_pc_plus4 : in_imm;
                end
            end
            m_slot = nslot;
            if (nslot) begin
                m_slot_addr = naddr; m_addr = naddr; m_data = ndata;
            end
            m_we = nslot && (naddr != 5'd0);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (live) begin
            chk("model.in_ready", {31'd0, in_ready}, {31'd0, !m_pending});
            chk("model.write_reg", {31'd0, write_reg}, {31'd0, m_we});
            chk("model.busy_mask", busy_mask, m_busy);
            chk("model.wb_err", {31'd0, wb_err}, {31'd0, m_err});
            if (m_we) begin
                chk("model.wr_addr", {27'd0, write_reg_addr}, {27'd0, m_addr});
                chk("model.wr_data", write_reg_data, m_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input logic [4:0] d, input bit wr, input logic [1:0] sel,
                        input logic [31:0] val, input bit rv, input logic [31:0] rd);
        in_valid = v; in_dest = d; in_write_reg = wr; in_wb_sel = sel;
        in_alu_result = (sel == 2'b00) ? val : 32'h5555_0000;
        in_imm        = (sel == 2'b11) ? val : 32'h6666_0000;
        in_pc_plus4   = (sel == 2'b10) ? val : 32'h7777_0000;
        mem_rvalid = rv; mem_rdata = rd;
        @(posedge clk); #1;
        in_valid = 1'b0; in_write_reg = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 2'b00, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("rst.write_reg", {31'd0, write_reg}, 32'd0);
        chk("rst.data", write_reg_data, 32'd0);
        chk("rst.addr", {27'd0, write_reg_addr}, 32'd0);
        chk("rst.busy", busy_mask, 32'd0);
        chk("rst.err", {31'd0, wb_err}, 32'd0);
        chk("rst.ready", {31'd0, in_ready}, 32'd1);
        idle(1);

        // ALU writeback r5
        step(1'b1, 5'd5, 1'b1, 2'b00, 32'h0000_1234, 1'b0, 32'd0);
        chk("alu.we", {31'd0, write_reg}, 32'd1);
        chk("alu.addr", {27'd0, write_reg_addr}, 32'd5);
        chk("alu.data", write_reg_data, 32'h0000_1234);
        idle(1);
        chk("alu.we_drop", {31'd0, write_reg}, 32'd0);

        // Bubble: valid but no register write
        step(1'b1, 5'd6, 1'b0, 2'b00, 32'h0BAD_0BAD, 1'b0, 32'd0);
        chk("bubble.we", {31'd0, write_reg}, 32'd0);

        // Load r7, data on the last allowed wait cycle
        step(1'b1, 5'd7, 1'b1, 2'b01, 32'd0, 1'b0, 32'd0);
        chk("ld.busy", busy_mask, 32'h0000_0080);
        chk("ld.ready", {31'd0, in_ready}, 32'd0);
        idle(3);
        step(1'b0, 5'd0, 1'b0, 2'b00, 32'd0, 1'b1, 32'hDEAD_BEEF);
        chk("ld.we", {31'd0, write_reg}, 32'd1);
        chk("ld.addr", {27'd0, write_reg_addr}, 32'd7);
        chk("ld.data", write_reg_data, 32'hDEAD_BEEF);
        chk("ld.ready_back", {31'd0, in_ready}, 32'd1);
        idle(1);
        chk("ld.busy_clr", busy_mask, 32'd0);
        chk("ld.err", {31'd0, wb_err}, 32'd0);

        // Back-to-back writes
        step(1'b1, 5'd1, 1'b1, 2'b00, 32'h0000_0001, 1'b0, 32'd0);
        chk("b2b.d1", write_reg_data, 32'h0000_0001);
        step(1'b1, 5'd2, 1'b1, 2'b11, 32'hFFFF_FFF0, 1'b0, 32'd0);
        chk("b2b.d2", write_reg_data, 32'hFFFF_FFF0);
        chk("b2b.we2", {31'd0, write_reg}, 32'd1);
        step(1'b1, 5'd31, 1'b1, 2'b10, 32'h0000_0104, 1'b0, 32'd0);
        chk("b2b.d3", write_reg_data, 32'h0000_0104);
        chk("b2b.a3", {27'd0, write_reg_addr}, 32'd31);
        idle(1);

        // Write then load issued back-to-back from WRITE state
        step(1'b1, 5'd4, 1'b1, 2'b00, 32'h0000_0044, 1'b0, 32'd0);
        step(1'b1, 5'd12, 1'b1, 2'b01, 32'd0, 1'b0, 32'd0);
        chk("wl.busy", busy_mask, 32'h0000_1000);
        step(1'b0, 5'd0, 1'b0, 2'b00, 32'd0, 1'b1, 32'h0000_0C0C);
        chk("wl.data", write_reg_data, 32'h0000_0C0C);
        idle(1);

        // Timeout on load to r3
        step(1'b1, 5'd3, 1'b1, 2'b01, 32'd0, 1'b0, 32'd0);
        idle(3);
        chk("to.pre_err", {31'd0, wb_err}, 32'd0);
        idle(1);
        chk("to.err", {31'd0, wb_err}, 32'd1);
        chk("to.busy", busy_mask, 32'd0);
        chk("to.we", {31'd0, write_reg}, 32'd0);
        chk("to.ready", {31'd0, in_ready}, 32'd1);
        // Late data after the timeout is ignored
        step(1'b0, 5'd0, 1'b0, 2'b00, 32'd0, 1'b1, 32'h1111_1111);
        chk("to.late_we", {31'd0, write_reg}, 32'd0);

        // r0 suppression
        step(1'b1, 5'd0, 1'b1, 2'b00, 32'hAAAA_AAAA, 1'b0, 32'd0);
        chk("r0.we", {31'd0, write_reg}, 32'd0);
        step(1'b1, 5'd0, 1'b1, 2'b01, 32'd0, 1'b0, 32'd0);
        chk("r0.busy", busy_mask, 32'd0);
        chk("r0.ready", {31'd0, in_ready}, 32'd0);
        step(1'b0, 5'd0, 1'b0, 2'b00, 32'd0, 1'b1, 32'h2222_2222);
        chk("r0.ld_we", {31'd0, write_reg}, 32'd0);
        idle(1);

        // Reset mid-load
        step(1'b1, 5'd9, 1'b1, 2'b01, 32'd0, 1'b0, 32'd0);
        chk("rml.busy", busy_mask, 32'h0000_0200);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rml.busy0", busy_mask, 32'd0);
        chk("rml.err0", {31'd0, wb_err}, 32'd0);
        chk("rml.ready", {31'd0, in_ready}, 32'd1);
        chk("rml.data0", write_reg_data, 32'd0);
        step(1'b0, 5'd0, 1'b0, 2'b00, 32'd0, 1'b1, 32'h3333_3333);
        chk("rml.we", {31'd0, write_reg}, 32'd0);
        chk("rml.err", {31'd0, wb_err}, 32'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
